// File: rtl/fa_pkg.sv
// Shared types and constants for the serial full-adder initiator.
package fa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } fa_state_e;

    // Pipeline depth of the external 1-bit full adder.
    localparam int unsigned FA_LATENCY = 2;

    // Cycles spent per operand bit: one issue cycle plus the adder latency.
    localparam int unsigned BITS_PER_CYCLE_COST = FA_LATENCY + 1;

endpackage

// File: rtl/fa_serial_driver.sv
// Serial initiator for a 2-stage 1-bit full adder: takes WIDTH-bit add requests,
// issues them one bit at a time LSB first, chains the carry and returns the sum.
// Optional macro FA_TIMEOUT_EN: abort a bit that gets no adder response within
// TIMEOUT cycles and return the partial sum with rsp_error set.
module fa_serial_driver
    import fa_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic             fa_in_valid,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_out_valid,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_error
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    // Reject configurations the bit-serial datapath cannot handle.
    if (WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("fa_serial_driver: WIDTH must be >= 2 and TIMEOUT >= 1");
    end

    fa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;

`ifdef FA_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
`ifdef FA_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
`ifdef FA_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
`ifdef FA_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        req_ready   = 1'b0;
        fa_in_valid = 1'b0;
        fa_a        = 1'b0;
        fa_b        = 1'b0;
        fa_cin      = 1'b0;
        rsp_valid   = 1'b0;
        rsp_sum     = '0;
        rsp_cout    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Registered state is already IDLE during reset, so gate ready explicitly.
                req_ready = !reset;
                if (req_valid && req_ready) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    carry_d = req_cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fa_in_valid = 1'b1;
                fa_a        = a_q[idx_q];
                fa_b        = b_q[idx_q];
                fa_cin      = carry_q;
`ifdef FA_TIMEOUT_EN
                cnt_d       = '0;
`endif
                state_d     = WAIT;
            end
            WAIT: begin
                if (fa_out_valid) begin
                    sum_d[idx_q] = fa_sum;
                    carry_d      = fa_cout;
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        state_d = RESP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
`ifdef FA_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_sum   = sum_q;
                rsp_cout  = carry_q;
                if (rsp_ready) begin
`ifdef FA_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FA_TIMEOUT_EN
    assign rsp_error = err_q;
`else
    assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_fa_serial_driver.sv
// Bench for fa_serial_driver with a behavioural 2-stage full adder alongside it.
// Honours FA_TIMEOUT_EN to pick the expected timeout behaviour.
module tb_fa_serial_driver;
    import fa_pkg::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned LAT     = BITS_PER_CYCLE_COST * WIDTH + 1;
    localparam int unsigned NRAND   = 500;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid, req_ready, req_cin;
    logic [WIDTH-1:0] req_a, req_b;
    logic             fa_in_valid, fa_a, fa_b, fa_cin;
    logic             fa_out_valid, fa_sum, fa_cout;
    logic             rsp_valid, rsp_ready, rsp_cout, rsp_error;
    logic [WIDTH-1:0] rsp_sum;

    // Adder model plus bench-side masking and stale-result injection.
    logic v1, s1, c1, v2, s2, c2;
    logic mask, inj_v, inj_s, inj_c;
    logic fa_rst_n;

    int cyc = 0;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fa_rst_n = !reset;

    always_ff @(posedge clk or negedge fa_rst_n) begin
        if (!fa_rst_n) begin
            {v1, s1, c1, v2, s2, c2} <= '0;
        end else begin
            v1       <= fa_in_valid;
            {c1, s1} <= 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);
            v2       <= v1;
            s2       <= s1;
            c2       <= c1;
        end
    end

    assign fa_out_valid = (v2 && !mask) || inj_v;
    assign fa_sum       = inj_v ? inj_s : s2;
    assign fa_cout      = inj_v ? inj_c : c2;

    fa_serial_driver #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cin      (req_cin),
        .fa_in_valid  (fa_in_valid),
        .fa_a         (fa_a),
        .fa_b         (fa_b),
        .fa_cin       (fa_cin),
        .fa_out_valid (fa_out_valid),
        .fa_sum       (fa_sum),
        .fa_cout      (fa_cout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_sum      (rsp_sum),
        .rsp_cout     (rsp_cout),
        .rsp_error    (rsp_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One full transaction from IDLE; hold = cycles of rsp_ready backpressure.
    task automatic run_req(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                           input int hold);
        int acc, lat, pulses, last;
        bit gap_ok, stable_ok;
        logic [WIDTH-1:0] s;
        logic co;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        check({name, "_req_ready"}, 32'(req_ready), 32'd1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0; last = -1; gap_ok = 1'b1; lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (fa_in_valid) begin
                if (last >= 0 && cyc - last != int'(BITS_PER_CYCLE_COST)) gap_ok = 1'b0;
                last = cyc;
                pulses++;
            end
            if (rsp_valid) begin
                lat = cyc - acc;
                break;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_pulses"}, 32'(pulses), 32'(WIDTH));
        check({name, "_pulse_gap"}, 32'(gap_ok), 32'd1);
        check({name, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        check({name, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        s = rsp_sum; co = rsp_cout; stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_sum !== s || rsp_cout !== co || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        if (hold > 0) check({name, "_backpressure_stable"}, 32'(stable_ok), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_done"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [WIDTH:0] exp_q[$];
        logic [WIDTH:0] e;
        int sent, got, pulses, t_issue, r;
        bit seen_bad, need_new;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0;
        rsp_ready = 1'b0; mask = 1'b0; inj_v = 1'b0; inj_s = 1'b0; inj_c = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {req_ready, fa_in_valid, fa_a, fa_b, fa_cin, rsp_valid,
                                rsp_cout, rsp_error, rsp_sum}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i])
            run_req($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].sum, vecs[i].cout, 0);

        run_req("backpressure", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5);

        // Reset in the middle of bit 3.
        @(negedge clk);
        req_a = 8'hAA; req_b = 8'h55; req_cin = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 100 && pulses < 4; i++) begin
            if (fa_in_valid) pulses++;
            if (pulses < 4) @(negedge clk);
        end
        check("midreset_reached_bit3", 32'(pulses), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs", {req_ready, fa_in_valid, fa_a, fa_b, fa_cin, rsp_valid,
                                   rsp_cout, rsp_error, rsp_sum}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        inj_v = 1'b1; inj_s = 1'b1; inj_c = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        check("stale_result_ignored", {29'd0, req_ready, rsp_valid, fa_in_valid}, 32'b100);
        run_req("after_reset", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

        // Adder response withheld from bit 2 onwards.
        @(negedge clk);
        req_a = 8'h5A; req_b = 8'h3C; req_cin = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        pulses = 0; t_issue = -1;
        for (int i = 0; i < 100 && pulses < 3; i++) begin
            if (fa_in_valid) pulses++;
            if (pulses == 3) t_issue = cyc;
            else @(negedge clk);
        end
        mask = 1'b1;
        check("timeout_reached_bit2", 32'(pulses), 32'd3);
`ifdef FA_TIMEOUT_EN
        r = -1;
        for (int i = 0; i < 4 * TIMEOUT + 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = cyc;
                break;
            end
        end
        check("timeout_delay", 32'(r - (t_issue + 1)), 32'(TIMEOUT));
        check("timeout_error", 32'(rsp_error), 32'd1);
        check("timeout_partial_sum", 32'(rsp_sum), 32'h02);
        check("timeout_cout", 32'(rsp_cout), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("timeout_error_cleared", {30'd0, rsp_valid, rsp_error}, 32'd0);
        mask = 1'b0;
`else
        seen_bad = 1'b0;
        for (int i = 0; i < 4 * TIMEOUT + 20; i++) begin
            @(negedge clk);
            if (rsp_valid || rsp_error || fa_in_valid || req_ready) seen_bad = 1'b1;
        end
        check("wait_holds_forever", 32'(seen_bad), 32'd0);
        mask = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif

        // Random back-to-back traffic against a queue of arithmetic sums.
        sent = 0; got = 0; need_new = 1'b1;
        for (int c = 0; c < 40000 && got < int'(NRAND); c++) begin
            @(negedge clk);
            if (need_new) begin
                need_new = 1'b0;
                if (sent < int'(NRAND)) begin
                    req_a = WIDTH'($urandom); req_b = WIDTH'($urandom);
                    req_cin = 1'($urandom); req_valid = 1'b1;
                end else begin
                    req_valid = 1'b0;
                end
            end
            rsp_ready = 1'($urandom_range(0, 1));
            if (req_valid && req_ready) begin
                exp_q.push_back((WIDTH + 1)'(req_a) + (WIDTH + 1)'(req_b) + (WIDTH + 1)'(req_cin));
                sent++;
                need_new = 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check($sformatf("rand%0d", got), 32'({rsp_cout, rsp_sum}), 32'(e));
                got++;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rand_all_responses", 32'(got), 32'(NRAND));
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fa_serial_driver.md
Name: fa_serial_driver

Overview:
- Initiator side of the 1-bit pipelined full-adder interface (in_valid/a/b/cin out, out_valid/sum/cout in).
- Accepts WIDTH-bit add requests over a valid/ready handshake and issues them to the external 2-stage full adder one bit at a time, LSB first.
- Feeds each returned cout back as the next bit's cin, assembles the sum, and returns it over a valid/ready response handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- TIMEOUT, 8, max cycles waiting for fa_out_valid before abort (used only with FA_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in for bit 0.
- fa_in_valid  out  1  to adder in_valid.
- fa_a  out  1  to adder a.
- fa_b  out  1  to adder b.
- fa_cin  out  1  to adder cin.
- fa_out_valid  in  1  from adder out_valid.
- fa_sum  in  1  from adder sum.
- fa_cout  in  1  from adder cout.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_sum  out  WIDTH  assembled sum.
- rsp_cout  out  1  final carry-out.
- rsp_error  out  1  timeout abort flag; constant 0 without FA_TIMEOUT_EN.

Behaviour:
- Reset, asynchronous while high:
  - State IDLE; all outputs 0 (req_ready 0 while reset is asserted).
  - Bit index, carry and sum registers cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture req_a, req_b; carry<=req_cin; idx<=0; sum_reg<=0; go to ISSUE.
- ISSUE (exactly one cycle):
  - fa_in_valid=1, fa_a=a_reg[idx], fa_b=b_reg[idx], fa_cin=carry.
  - Go to WAIT.
- WAIT:
  - fa_in_valid=0.
  - On fa_out_valid: sum_reg[idx]<=fa_sum; carry<=fa_cout.
  - If idx==WIDTH-1 go to RESP, else idx<=idx+1 and go to ISSUE.
- RESP:
  - rsp_valid=1; rsp_sum=sum_reg; rsp_cout=carry; all held stable until rsp_ready.
  - On rsp_valid&rsp_ready go to IDLE.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Outside ISSUE, fa_in_valid/fa_a/fa_b/fa_cin are driven 0.
- At most one bit is in flight at a time; the adder latency is 2, so each bit takes 3 cycles.
- Latency: rsp_valid rises 3*WIDTH+1 cycles after the accept cycle (25 cycles for WIDTH=8).
- fa_out_valid outside WAIT, including stale in-flight results after reset, is ignored and does not alter state.
- Reset mid-operation: the request is dropped with no response; the block returns to IDLE.
- Arithmetic: {rsp_cout,rsp_sum} == req_a+req_b+req_cin, WIDTH+1 bits, no truncation.

Optional Feature:
- Macro: FA_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in WAIT and clears on entry to WAIT.
  - If TIMEOUT cycles elapse without fa_out_valid: go to RESP with rsp_error=1 and rsp_sum holding the bits completed so far.
  - rsp_error=0 for normal completion.
  - rsp_error is held with rsp_valid and cleared on handshake.
- Undefined: no counter; WAIT waits indefinitely; rsp_error tied 0.

Decomposition:
- Package fa_pkg holds:
  - state typedef enum {IDLE, ISSUE, WAIT, RESP};
  - localparam FA_LATENCY=2;
  - helper constant BITS_PER_CYCLE_COST=FA_LATENCY+1.
- No sub-module: a single FSM plus datapath registers. The bench instantiates the existing full adder alongside the block, sharing clk, with the adder's reset_n = !reset.

Test Plan:
- 0x5A+0x3C, cin=0 -> rsp_sum=0x96, rsp_cout=0, rsp_valid exactly 25 cycles after accept; fa_in_valid pulses 8 times, 3 cycles apart.
- 0xFF+0x01, cin=0 -> rsp_sum=0x00, rsp_cout=1. Then 0xFF+0xFF, cin=1 -> rsp_sum=0xFF, rsp_cout=1.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_sum/rsp_cout stable and req_ready=0 throughout; completes on the first rsp_ready cycle.
- Reset mid-operation at bit 3:
  - Outputs go to reset values; the in-flight fa_out_valid after release is ignored.
  - A following request 0x01+0x01 -> 0x02, cout=0.
- Random: 500 back-to-back requests with random rsp_ready -> every response equals req_a+req_b+req_cin.
- FA_TIMEOUT_EN: bench masks fa_out_valid at bit 2 -> rsp_valid with rsp_error=1, TIMEOUT cycles after entering WAIT. Without the macro -> FSM stays in WAIT and rsp_error stays 0.
